// File: rtl/mdu_controller_if.sv
// Signal bundle between mdu_controller and the EXE stage, pipelined multiplier and divider.
interface mdu_controller_if;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [63:0] hilo_i;
    logic        flush_i;
    logic        hold_i;
    logic        mul_start_o;
    logic        mul_signed_o;
    logic [63:0] mul_prod_i;
    logic        div_start_o;
    logic        div_signed_o;
    logic        div_abort_o;
    logic        div_done_i;
    logic [31:0] div_quot_i;
    logic [31:0] div_rem_i;
    logic [31:0] opa_o;
    logic [31:0] opb_o;
    logic [63:0] hilo_o;
    logic        hilo_we_o;
    logic        stall_o;
    logic        busy_o;

    modport master (
        input  op_i, a_i, b_i, hilo_i, flush_i, hold_i, mul_prod_i,
        input  div_done_i, div_quot_i, div_rem_i,
        output mul_start_o, mul_signed_o, div_start_o, div_signed_o, div_abort_o,
        output opa_o, opb_o, hilo_o, hilo_we_o, stall_o, busy_o
    );

    modport slave (
        output op_i, a_i, b_i, hilo_i, flush_i, hold_i, mul_prod_i,
        output div_done_i, div_quot_i, div_rem_i,
        input  mul_start_o, mul_signed_o, div_start_o, div_signed_o, div_abort_o,
        input  opa_o, opb_o, hilo_o, hilo_we_o, stall_o, busy_o
    );
endinterface

// File: rtl/mdu_controller.sv
// MDU sequencer: drives a fixed-latency multiplier and a handshaked divider, issues one HI/LO write.
// Define MDU_DIV_ZERO_FAST_EN to retire divide-by-zero at once without writing HI/LO.
module mdu_controller #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input logic              clk,
    input logic              rst,
    mdu_controller_if.master bus
);
    typedef enum logic [2:0] {StIdle, StMulWait, StDivWait, StAcc, StDone} state_e;

    localparam logic [3:0] LatLast = 4'(MUL_LATENCY);

    state_e      state_q;
    logic [3:0]  op_q;
    logic [3:0]  cnt_q;
    logic        signed_q;
    logic        mul_start_q;
    logic        div_start_q;
    logic        we_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [63:0] prod_q;
    logic [63:0] hilo_q;

    logic op_valid;
    logic op_is_div;
    logic op_is_mul;
    logic acc_add;

    always_comb begin
        op_valid  = (bus.op_i != 4'd0) && (bus.op_i <= 4'd8);
        op_is_div = (bus.op_i == 4'd3) || (bus.op_i == 4'd4);
        op_is_mul = (op_q == 4'd1) || (op_q == 4'd2);
        acc_add   = (op_q == 4'd5) || (op_q == 4'd6);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 4'd0;
            cnt_q       <= 4'd0;
            signed_q    <= 1'b0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            we_q        <= 1'b0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            prod_q      <= 64'd0;
            hilo_q      <= 64'd0;
        end else begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            we_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (op_valid && !bus.flush_i) begin
                        opa_q    <= bus.a_i;
                        opb_q    <= bus.b_i;
                        op_q     <= bus.op_i;
                        // Signed variants are the odd op codes.
                        signed_q <= bus.op_i[0];
                        cnt_q    <= 4'd0;
                        if (op_is_div) begin
`ifdef MDU_DIV_ZERO_FAST_EN
                            if (bus.b_i == 32'd0) begin
                                state_q <= StDone;
                            end else begin
                                state_q     <= StDivWait;
                                div_start_q <= 1'b1;
                            end
`else
                            state_q     <= StDivWait;
                            div_start_q <= 1'b1;
`endif
                        end else begin
                            state_q     <= StMulWait;
                            mul_start_q <= 1'b1;
                        end
                    end
                end
                StMulWait: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q == LatLast) begin
                        if (op_is_mul) begin
                            hilo_q  <= bus.mul_prod_i;
                            we_q    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            prod_q  <= bus.mul_prod_i;
                            state_q <= StAcc;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StAcc: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        hilo_q  <= acc_add ? bus.hilo_i + prod_q : bus.hilo_i - prod_q;
                        we_q    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDivWait: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                    end else if (bus.div_done_i && !div_start_q) begin
                        hilo_q  <= {bus.div_rem_i, bus.div_quot_i};
                        we_q    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!bus.hold_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mul_start_o  = mul_start_q;
    assign bus.mul_signed_o = signed_q;
    assign bus.div_start_o  = div_start_q;
    assign bus.div_signed_o = signed_q;
    // Abort is combinational so the divider drops its work in the same cycle as the kill.
    assign bus.div_abort_o  = (state_q == StDivWait) && (bus.flush_i || rst);
    assign bus.opa_o        = opa_q;
    assign bus.opb_o        = opb_q;
    assign bus.hilo_o       = hilo_q;
    assign bus.hilo_we_o    = we_q && !bus.flush_i && !rst;
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.stall_o      = !rst && (((state_q == StIdle) && op_valid && !bus.flush_i) ||
                                       (state_q == StMulWait) || (state_q == StDivWait) ||
                                       (state_q == StAcc));
endmodule

// File: tb/tb_mdu_controller.sv
// Self-checking bench for mdu_controller: multiplier/divider models plus a HI/LO write scoreboard.
module tb_mdu_controller;
    localparam int MulLat = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_controller_if bus ();

    mdu_controller #(.MUL_LATENCY(MulLat)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] hilo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int abort_cnt = 0;
    int dstart_cnt = 0;
    int mstart_cnt = 0;
    int mcnt = -1;
    int dcnt = -1;
    int div_lat = 10;
    logic stray_done = 1'b0;
    logic [63:0] mprod = 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Resource models: pipelined multiplier and iterative divider.
    always begin
        @(negedge clk);
        #1;
        if (mcnt >= 0) mcnt--;
        if (bus.mul_start_o) begin
            mcnt = MulLat;
            if (bus.mul_signed_o)
                mprod = $signed({{32{bus.opa_o[31]}}, bus.opa_o}) *
                        $signed({{32{bus.opb_o[31]}}, bus.opb_o});
            else
                mprod = {32'd0, bus.opa_o} * {32'd0, bus.opb_o};
        end
        bus.mul_prod_i = (mcnt == 0) ? mprod : 64'hBAD0_BAD0_BAD0_BAD0;

        if (bus.div_abort_o) dcnt = -1;
        else if (dcnt >= 0) dcnt--;
        if (bus.div_start_o) begin
            dcnt = div_lat;
            if (bus.opb_o == 32'd0) begin
                bus.div_quot_i = 32'hFFFF_FFFF;
                bus.div_rem_i  = bus.opa_o;
            end else if (bus.div_signed_o) begin
                bus.div_quot_i = $signed(bus.opa_o) / $signed(bus.opb_o);
                bus.div_rem_i  = $signed(bus.opa_o) % $signed(bus.opb_o);
            end else begin
                bus.div_quot_i = bus.opa_o / bus.opb_o;
                bus.div_rem_i  = bus.opa_o % bus.opb_o;
            end
        end
        bus.div_done_i = (dcnt == 0) || stray_done;
    end

    // Monitor: every HI/LO write must match the oldest expected result and its cycle.
    always begin
        @(negedge clk);
        #2;
        if (bus.mul_start_o) mstart_cnt++;
        if (bus.div_start_o) dstart_cnt++;
        if (bus.div_abort_o) abort_cnt++;
        if (bus.hilo_we_o) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_we", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("hilo", bus.hilo_o, mon_e.hilo);
                check("we_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && bus.busy_o; i++) @(negedge clk);
        check(tag, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hilo, input logic [63:0] exp_hilo, input int lat,
                          input string tag);
        @(negedge clk);
        bus.op_i   = op;
        bus.a_i    = a;
        bus.b_i    = b;
        bus.hilo_i = hilo;
        exp_q.push_back('{exp_hilo, cyc + lat});
        @(negedge clk);
        bus.op_i = 4'd0;
        wait_idle(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int a0;
        int m0;
        int d0;
        bus.op_i    = 4'd0;
        bus.a_i     = 32'd0;
        bus.b_i     = 32'd0;
        bus.hilo_i  = 64'd0;
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hilo", bus.hilo_o, 64'd0);
        check("rst_ops", {bus.opa_o, bus.opb_o}, 64'd0);
        check("rst_ctl", 64'({bus.busy_o, bus.stall_o, bus.hilo_we_o, bus.mul_start_o,
                              bus.div_start_o, bus.div_abort_o, bus.mul_signed_o}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MULT with stall profile
        @(negedge clk);
        bus.op_i = 4'd1;
        bus.a_i  = 32'hFFFF_FFFF;
        bus.b_i  = 32'd2;
        exp_q.push_back('{64'hFFFF_FFFF_FFFF_FFFE, cyc + 2 + MulLat});
        #1 check("mult_stall_t0", 64'(bus.stall_o), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.op_i = 4'd0;
            #1 check($sformatf("mult_stall_t%0d", k), 64'(bus.stall_o), 64'(k < 4));
            if (k == 1) check("mult_start", 64'({bus.mul_start_o, bus.mul_signed_o}), 64'd3);
        end
        wait_idle("mult_idle");

        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, 2 + MulLat, "multu");
        run_op(4'd5, 32'd3, 32'd4, 64'h10, 64'h1C, 3 + MulLat, "madd");
        run_op(4'd7, 32'd3, 32'd4, 64'h10, 64'h4, 3 + MulLat, "msub");
        run_op(4'd5, 32'hFFFF_FFFF, 32'd5, 64'h10, 64'hB, 3 + MulLat, "madd_neg");
        run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'h0000_0001_FFFF_FFFF,
               3 + MulLat, "msubu_wrap");
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 2 + div_lat, "div");
        run_op(4'd4, 32'd100, 32'd7, 64'd0, {32'd2, 32'd14}, 2 + div_lat, "divu");

        // DIVU killed by flush, then a late done must be ignored
        w0 = we_cnt;
        a0 = abort_cnt;
        @(negedge clk);
        bus.op_i = 4'd4;
        bus.a_i  = 32'd50;
        bus.b_i  = 32'd3;
        @(negedge clk);
        bus.op_i = 4'd0;
        repeat (3) @(negedge clk);
        bus.flush_i = 1'b1;
        #1 check("flush_abort", 64'(bus.div_abort_o), 64'd1);
        @(negedge clk);
        bus.flush_i = 1'b0;
        stray_done  = 1'b1;
        #1 check("flush_idle", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_no_we", 64'(we_cnt - w0), 64'd0);
        check("flush_one_abort", 64'(abort_cnt - a0), 64'd1);

        // Reserved op codes are ignored
        @(negedge clk);
        bus.op_i = 4'd9;
        #1 check("op9_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.op_i = 4'd0;
        #1 check("op9_busy", 64'(bus.busy_o), 64'd0);

        // MULT retiring under hold: one write, stays in DONE, no restart
        w0 = we_cnt;
        m0 = mstart_cnt;
        @(negedge clk);
        bus.op_i   = 4'd1;
        bus.a_i    = 32'd7;
        bus.b_i    = 32'd6;
        bus.hold_i = 1'b1;
        exp_q.push_back('{64'd42, cyc + 2 + MulLat});
        @(negedge clk);
        bus.op_i = 4'd0;
        repeat (6) @(negedge clk);
        #1 check("hold_busy", 64'(bus.busy_o), 64'd1);
        check("hold_hilo", bus.hilo_o, 64'd42);
        bus.hold_i = 1'b0;
        @(negedge clk);
        #1 check("hold_release", 64'(bus.busy_o), 64'd0);
        check("hold_one_we", 64'(we_cnt - w0), 64'd1);
        check("hold_no_restart", 64'(mstart_cnt - m0), 64'd1);

        // Reset in the middle of a divide
        a0 = abort_cnt;
        w0 = we_cnt;
        @(negedge clk);
        bus.op_i = 4'd3;
        bus.a_i  = 32'd9;
        bus.b_i  = 32'd4;
        @(negedge clk);
        bus.op_i = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("rst_abort", 64'(bus.div_abort_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_idle", 64'(bus.busy_o), 64'd0);
        repeat (12) @(negedge clk);
        check("rst_no_we", 64'(we_cnt - w0), 64'd0);

        // Divide by zero
        w0 = we_cnt;
        d0 = dstart_cnt;
`ifdef MDU_DIV_ZERO_FAST_EN
        @(negedge clk);
        bus.op_i = 4'd3;
        bus.a_i  = 32'd5;
        bus.b_i  = 32'd0;
        @(negedge clk);
        bus.op_i = 4'd0;
        #1 check("dz_stall", 64'(bus.stall_o), 64'd0);
        wait_idle("dz_idle");
        repeat (2) @(negedge clk);
        check("dz_no_start", 64'(dstart_cnt - d0), 64'd0);
        check("dz_no_we", 64'(we_cnt - w0), 64'd0);
`else
        run_op(4'd4, 32'd5, 32'd0, 64'd0, {32'd5, 32'hFFFF_FFFF}, 2 + div_lat, "divz");
        repeat (2) @(negedge clk);
        check("dz_start", 64'(dstart_cnt - d0), 64'd1);
        check("dz_we", 64'(we_cnt - w0), 64'd1);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
